// File: rtl/pmem_arb_pkg.sv
// Shared types and width defaults for the I/D physical-memory arbiter.
package pmem_arb_pkg;

    localparam int PMEM_ADDR_W = 32;
    localparam int PMEM_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_I   = 2'd1,
        GNT_D   = 2'd2,
        RELEASE = 2'd3
    } pmem_arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } pmem_arb_owner_t;

endpackage

// File: rtl/pmem_arb_pick.sv
// Grant selection between I- and D-cache requests.
// PMEM_ARB_RR_EN: round-robin on conflict; otherwise D-cache has fixed priority.
module pmem_arb_pick
    import pmem_arb_pkg::*;
(
    input  logic            i_req,
    input  logic            d_req,
`ifdef PMEM_ARB_RR_EN
    input  pmem_arb_owner_t last_owner,
`endif
    output logic            gnt_valid,
    output pmem_arb_owner_t gnt_owner
);

    always_comb begin
        gnt_valid = i_req | d_req;
        gnt_owner = d_req ? OWNER_D : OWNER_I;
        if (i_req && d_req) begin
`ifdef PMEM_ARB_RR_EN
            gnt_owner = (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
`else
            gnt_owner = OWNER_D;
`endif
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates the shared 256-bit pmem port between I-cache and D-cache.
// Optional round-robin conflict resolution via PMEM_ARB_RR_EN.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = PMEM_ADDR_W,
    parameter int LINE_W = PMEM_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    pmem_arb_state_t state, state_nxt;
    pmem_arb_owner_t gnt_owner;
    logic            gnt_valid;
    logic            write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
`ifdef PMEM_ARB_RR_EN
    pmem_arb_owner_t last_owner;
`endif

    pmem_arb_pick u_pick (
        .i_req      (i_pmem_read),
        .d_req      (d_pmem_read | d_pmem_write),
`ifdef PMEM_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner)
    );

    // Request is captured only on the grant edge; later changes by the owner are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef PMEM_ARB_RR_EN
            last_owner <= OWNER_I;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt_valid) begin
                write_q <= (gnt_owner == OWNER_D) && d_pmem_write;
                addr_q  <= (gnt_owner == OWNER_D) ? d_pmem_address : i_pmem_address;
                wdata_q <= d_pmem_wdata;
`ifdef PMEM_ARB_RR_EN
                last_owner <= gnt_owner;
`endif
            end
        end
    end

    // RELEASE gives the finished requester a cycle to drop its level-held request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (gnt_valid) state_nxt = (gnt_owner == OWNER_D) ? GNT_D : GNT_I;
            GNT_I, GNT_D: if (pmem_resp) state_nxt = RELEASE;
            RELEASE:     state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (state)
            GNT_I: begin
                pmem_read   = ~write_q;
                pmem_write  = write_q;
                i_pmem_resp = pmem_resp;
            end
            GNT_D: begin
                pmem_read   = ~write_q;
                pmem_write  = write_q;
                d_pmem_resp = pmem_resp;
            end
            default: ;
        endcase
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter (fixed or round-robin build).
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int vectors = 0;
    int errors  = 0;
    int i_resp_cnt = 0;
    int d_resp_cnt = 0;
    int rd_cycles  = 0;

    pmem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i_pmem_resp === 1'b1) i_resp_cnt++;
        if (d_pmem_resp === 1'b1) d_resp_cnt++;
        if (pmem_read === 1'b1) rd_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0)
            begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
        vectors++;
        if (pmem_address !== 32'h0 || pmem_wdata !== 256'h0)
            begin errors++; $display("FAIL reset_regs addr=%h wdata_lo=%h exp=0", pmem_address, pmem_wdata[31:0]); end
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({pmem_read, pmem_write} !== 2'b00)
            begin errors++; $display("FAIL reset_idle got=%b exp=00", {pmem_read, pmem_write}); end
    endtask

    task automatic test_i_read();
        logic [255:0] line;
        int c_i, c_d;
        line = {8{32'hC0DE_1000}};
        c_i = i_resp_cnt; c_d = d_resp_cnt;
        i_pmem_address = 32'h0000_1000;
        i_pmem_read = 1'b1;
        #1;
        vectors++;
        if (pmem_read !== 1'b0) begin errors++; $display("FAIL i_lat0 pmem_read=%b exp=0", pmem_read); end
        tick();
        vectors++;
        if ({pmem_read, pmem_write} !== 2'b10 || pmem_address !== 32'h0000_1000)
            begin errors++; $display("FAIL i_grant rd/wr=%b addr=%h exp=10 00001000", {pmem_read, pmem_write}, pmem_address); end
        repeat (3) tick();
        vectors++;
        if (pmem_read !== 1'b1 || i_pmem_resp !== 1'b0)
            begin errors++; $display("FAIL i_hold pmem_read=%b i_resp=%b exp=1 0", pmem_read, i_pmem_resp); end
        pmem_rdata = line;
        pmem_resp = 1'b1;
        #1;
        vectors++;
        if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0 || i_pmem_rdata !== line || d_pmem_rdata !== line)
            begin errors++; $display("FAIL i_resp i_resp=%b d_resp=%b rdata_lo=%h exp=1 0 %h", i_pmem_resp, d_pmem_resp, i_pmem_rdata[31:0], line[31:0]); end
        tick();
        pmem_resp = 1'b0;
        i_pmem_read = 1'b0;
        vectors++;
        if (pmem_read !== 1'b0) begin errors++; $display("FAIL i_release pmem_read=%b exp=0", pmem_read); end
        tick();
        vectors++;
        if (i_resp_cnt - c_i != 1 || d_resp_cnt - c_d != 0)
            begin errors++; $display("FAIL i_resp_count i=%0d d=%0d exp=1 0", i_resp_cnt - c_i, d_resp_cnt - c_d); end
    endtask

    task automatic test_d_write();
        logic [255:0] wd;
        int c_i, c_d, c_rd;
        wd = {32{8'hA5}};
        c_i = i_resp_cnt; c_d = d_resp_cnt; c_rd = rd_cycles;
        d_pmem_address = 32'h0000_2020;
        d_pmem_wdata = wd;
        d_pmem_write = 1'b1;
        tick();
        vectors++;
        if ({pmem_read, pmem_write} !== 2'b01 || pmem_address !== 32'h0000_2020 || pmem_wdata !== wd)
            begin errors++; $display("FAIL d_grant rd/wr=%b addr=%h wdata_lo=%h exp=01 00002020 a5a5a5a5", {pmem_read, pmem_write}, pmem_address, pmem_wdata[31:0]); end
        d_pmem_address = 32'hFFFF_FFE0;
        d_pmem_wdata = '0;
        tick();
        tick();
        vectors++;
        if (pmem_address !== 32'h0000_2020 || pmem_wdata !== wd)
            begin errors++; $display("FAIL d_latched addr=%h wdata_lo=%h exp=00002020 a5a5a5a5", pmem_address, pmem_wdata[31:0]); end
        pmem_resp = 1'b1;
        #1;
        vectors++;
        if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0)
            begin errors++; $display("FAIL d_resp d=%b i=%b exp=1 0", d_pmem_resp, i_pmem_resp); end
        tick();
        pmem_resp = 1'b0;
        d_pmem_write = 1'b0;
        vectors++;
        if (pmem_write !== 1'b0) begin errors++; $display("FAIL d_release pmem_write=%b exp=0", pmem_write); end
        tick();
        vectors++;
        if (d_resp_cnt - c_d != 1 || i_resp_cnt - c_i != 0 || rd_cycles - c_rd != 0)
            begin errors++; $display("FAIL d_counts d=%0d i=%0d rd=%0d exp=1 0 0", d_resp_cnt - c_d, i_resp_cnt - c_i, rd_cycles - c_rd); end
    endtask

    task automatic test_resp_idle();
        pmem_resp = 1'b1;
        #1;
        vectors++;
        if ({i_pmem_resp, d_pmem_resp, pmem_read, pmem_write} !== 4'b0)
            begin errors++; $display("FAIL resp_idle got=%b exp=0000", {i_pmem_resp, d_pmem_resp, pmem_read, pmem_write}); end
        tick();
        pmem_resp = 1'b0;
    endtask

    task automatic test_rw_both();
        d_pmem_address = 32'h0000_5000;
        d_pmem_read = 1'b1;
        d_pmem_write = 1'b1;
        tick();
        vectors++;
        if ({pmem_read, pmem_write} !== 2'b01)
            begin errors++; $display("FAIL rw_both rd/wr=%b exp=01", {pmem_read, pmem_write}); end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit rr;
        bit exp_d;
        int n;
`ifdef PMEM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        i_pmem_address = 32'h0000_1000;
        d_pmem_address = 32'h0000_3000;
        i_pmem_read = 1'b1;
        d_pmem_read = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (pmem_read !== 1'b1 && n < 8) begin tick(); n++; end
            exp_d = rr ? (g % 2 == 0) : 1'b1;
            vectors++;
            if (n != ((g == 0) ? 1 : 2))
                begin errors++; $display("FAIL b2b_gap grant=%0d cycles=%0d exp=%0d", g, n, (g == 0) ? 1 : 2); end
            vectors++;
            if (pmem_address !== (exp_d ? 32'h0000_3000 : 32'h0000_1000))
                begin errors++; $display("FAIL b2b_owner grant=%0d addr=%h exp=%h", g, pmem_address, exp_d ? 32'h0000_3000 : 32'h0000_1000); end
            pmem_resp = 1'b1;
            #1;
            vectors++;
            if ({i_pmem_resp, d_pmem_resp} !== (exp_d ? 2'b01 : 2'b10))
                begin errors++; $display("FAIL b2b_resp grant=%0d i/d=%b exp=%b", g, {i_pmem_resp, d_pmem_resp}, exp_d ? 2'b01 : 2'b10); end
            tick();
            pmem_resp = 1'b0;
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int c_i;
        c_i = i_resp_cnt;
        i_pmem_address = 32'h0000_4000;
        i_pmem_read = 1'b1;
        tick();
        vectors++;
        if (pmem_read !== 1'b1) begin errors++; $display("FAIL rst_mid_grant pmem_read=%b exp=1", pmem_read); end
        #2;
        rst_n = 1'b0;
        pmem_resp = 1'b1;
        #1;
        vectors++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || pmem_address !== 32'h0)
            begin errors++; $display("FAIL rst_mid_drop got=%b addr=%h exp=0000 0", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address); end
        tick();
        pmem_resp = 1'b0;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (pmem_read !== 1'b0 || i_resp_cnt != c_i)
            begin errors++; $display("FAIL rst_mid_idle pmem_read=%b resps=%0d exp=0 0", pmem_read, i_resp_cnt - c_i); end
        tick();
        vectors++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_4000)
            begin errors++; $display("FAIL rst_mid_regrant pmem_read=%b addr=%h exp=1 00004000", pmem_read, pmem_address); end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        i_pmem_read = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        i_pmem_read = 1'b0;
        i_pmem_address = '0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata = '0;
        pmem_rdata = '0;
        pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_i_read();
        test_d_write();
        test_resp_idle();
        test_rw_both();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Arbitrates the single 256-bit physical-memory port between the instruction cache (read-only) and the data cache (read/write) of the pipelined core. Sits between the two caches' `pmem_*` ports and the cacheline adapter/main memory. Each granted transaction is latched and held until `pmem_resp`, and the response is routed back to the owner only.

## Interface
- `ADDR_W`, 32, physical address width
- `LINE_W`, 256, cacheline width
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `i_pmem_read` in 1: I-cache line fill request
- `i_pmem_address` in ADDR_W: I-cache line address
- `i_pmem_rdata` out LINE_W: fill data to I-cache
- `i_pmem_resp` out 1: I-cache transaction complete
- `d_pmem_read` in 1: D-cache line fill request
- `d_pmem_write` in 1: D-cache writeback request
- `d_pmem_address` in ADDR_W: D-cache line address
- `d_pmem_wdata` in LINE_W: D-cache writeback data
- `d_pmem_rdata` out LINE_W: fill data to D-cache
- `d_pmem_resp` out 1: D-cache transaction complete
- `pmem_read` out 1: memory read strobe
- `pmem_write` out 1: memory write strobe
- `pmem_address` out ADDR_W: memory address
- `pmem_wdata` out LINE_W: memory write data
- `pmem_rdata` in LINE_W: memory read data
- `pmem_resp` in 1: memory transaction complete

## Operation
- States:
  - `IDLE`: no owner.
  - `GNT_I`: I-cache owns the port.
  - `GNT_D`: D-cache owns the port.
  - `RELEASE`: one-cycle gap after completion.
- `IDLE`, evaluated every cycle:
  - No request: stay in `IDLE`.
  - Only one cache requesting: grant it.
  - Both requesting: pick per Configuration.
  - On the grant edge, latch address, wdata and the op (read or write) into registers. `pmem_*` outputs are driven from these registers only.
- `GNT_x`:
  - Drive `pmem_read` or `pmem_write` from the latched op.
  - When `pmem_resp=1`: pulse `x_pmem_resp=1` that same cycle, then go to `RELEASE`.
  - Memory strobes deassert on the edge after `pmem_resp`.
- `RELEASE` then `IDLE`. This gives the requester one cycle to drop its request so a stale request is not re-granted.
- `x_pmem_rdata = pmem_rdata` at all times, combinational. It is only meaningful when qualified by `x_pmem_resp`.
- `d_pmem_read` and `d_pmem_write` both high: treated as a write. Writeback precedes fill.
- Requester changing address/data while granted: ignored, because the values are latched.
- Requests are level-held by the caches until their resp. The arbiter never drops a granted transaction.
- `pmem_resp` while in `IDLE` or `RELEASE`: ignored, no resp forwarded.

## Timing
- Reset values:
  - State is `IDLE`.
  - `pmem_read`, `pmem_write`, `i_pmem_resp`, `d_pmem_resp` are 0.
  - `pmem_address` and `pmem_wdata` are 0.
  - Last-grant flag is `I`.
- Latency:
  - Request seen in `IDLE` at cycle 0 → `pmem_read`/`pmem_write` high at cycle 1.
  - Resp to the cache arrives in the same cycle as `pmem_resp`.
- Back-to-back: the next grant is asserted no earlier than 2 cycles after the completing `pmem_resp`. The extra cycle comes from `RELEASE`.
- Reset mid-transaction:
  - All strobes drop immediately (asynchronous).
  - State returns to `IDLE`.
  - No resp is generated.

## Configuration
- `PMEM_ARB_RR_EN` defined: round-robin on simultaneous requests. The cache not granted last wins. The last-grant flag updates on each grant.
- Undefined: fixed priority, D-cache always wins. The flag is absent.

## Structure
- `pmem_arb_pkg` holds:
  - the state enum `pmem_arb_state_t` (`IDLE`, `GNT_I`, `GNT_D`, `RELEASE`);
  - the owner enum `pmem_arb_owner_t` (`OWNER_I`, `OWNER_D`);
  - the `ADDR_W`/`LINE_W` defaults.
- One combinational sub-module, `pmem_arb_pick`. It takes the two request bits and the last owner, and returns the grant owner. The `PMEM_ARB_RR_EN` switch lives there.

## Test plan
- I-cache read only, addr 0x0000_1000, memory resp after 4 cycles:
  - `pmem_read` high from cycle 1.
  - `i_pmem_resp` pulses once with the line.
  - `d_pmem_resp` stays 0.
- D-cache write, addr 0x0000_2020, wdata all 0xA5:
  - `pmem_write` high and `pmem_wdata` matches.
  - `d_pmem_resp` is a single pulse.
  - `pmem_read` never asserted.
- Both request in the same cycle, held continuously:
  - Fixed mode: D, D, D…
  - `PMEM_ARB_RR_EN` mode: D, I, D, I.
  - Every pair of grants is separated by ≥1 `RELEASE` cycle.
- D-cache changes its address to 0xFFFF_FFE0 mid-grant: `pmem_address` stays at the latched 0x0000_2020 until resp.
- Assert `rst_n=0` while in `GNT_I` with `pmem_read=1`:
  - Strobes go to 0 before the next edge.
  - State returns to `IDLE` with no resp.
  - After release, a fresh I-cache request is granted in 1 cycle.
